// File: rtl/mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_ctrl_if
//  Bundles the request/response and RAM-side signals of the LC-3 memory
//  controller.
//
//  master modport : the requesters (core FSM and program loader). They drive
//                   the requests, MAR/MDR contents and loader address/data.
//                   They observe the RAM strobes and completion pulses.
//  slave modport  : the controller itself (mem_ctrl).
//
//  Signals
//   core_req   core memory request (MIO_EN), level
//   core_we    core request is a write (R_W)
//   mar_addr   MAR contents
//   mdr_data   MDR contents (core write data)
//   ldr_req    loader write request, level
//   ldr_addr   loader write address
//   ldr_wdata  loader write data
//   ram_addr   RAM address
//   ram_wdata  RAM write data
//   ram_we     RAM write strobe, one-cycle pulse
//   mdr_ld     load MDR, one-cycle pulse
//   mem_en     MDR input select = RAM data
//   mem_ready  LC-3 R, one-cycle pulse
//   ldr_ack    loader write done, one-cycle pulse
//   busy       controller not idle
// ---------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] mar_addr;
    logic [DW-1:0] mdr_data;
    logic          ldr_req;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic          mdr_ld;
    logic          mem_en;
    logic          mem_ready;
    logic          ldr_ack;
    logic          busy;

    modport master (
        output core_req, core_we, mar_addr, mdr_data,
        output ldr_req, ldr_addr, ldr_wdata,
        input  ram_addr, ram_wdata, ram_we, mdr_ld, mem_en,
        input  mem_ready, ldr_ack, busy
    );

    modport slave (
        input  core_req, core_we, mar_addr, mdr_data,
        input  ldr_req, ldr_addr, ldr_wdata,
        output ram_addr, ram_wdata, ram_we, mdr_ld, mem_en,
        output mem_ready, ldr_ack, busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//  Sequences the LC-3 MAR/MDR register pair against a fixed-latency 16-bit
//  RAM and shares the RAM port between the core FSM and a program loader.
//  Produces the MDR load/select strobes, the RAM write pulse and the LC-3
//  ready (R) signal.
//
//  Parameters
//   MEM_LAT  RAM access time in clk cycles (>= 1), reads and writes
//   AW       address width
//   DW       data width
//
//  Ports
//   clk    system clock, all state on posedge
//   rst_n  synchronous active-low reset
//   bus    mem_ctrl_if.slave: requests in, RAM strobes and completions out
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int MEM_LAT = 3,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_ctrl_if.slave bus
);

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CORE_ACC  = 2'd1,
        S_CORE_HOLD = 2'd2,
        S_LDR_ACC   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    // 1 = loader was granted last, so the core wins the next tie
    logic          last_ldr_q, last_ldr_d;

    logic          grant_core;
    logic          grant_ldr;
    logic          acc_done;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            last_ldr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            last_ldr_q <= last_ldr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        last_ldr_d = last_ldr_q;

        // Alternating arbitration: on a tie the requester that did not win
        // last time is served, so neither side can starve the other.
        grant_core = bus.core_req && (!bus.ldr_req || last_ldr_q);
        grant_ldr  = bus.ldr_req && !grant_core;

        case (state_q)
            S_IDLE: begin
                if (grant_core) begin
                    state_d    = S_CORE_ACC;
                    cnt_d      = CNT_INIT;
                    we_d       = bus.core_we;
                    last_ldr_d = 1'b0;
                end else if (grant_ldr) begin
                    state_d    = S_LDR_ACC;
                    cnt_d      = CNT_INIT;
                    last_ldr_d = 1'b1;
                end
            end

            // Request drops during the access are ignored: once granted,
            // the access always runs to completion.
            S_CORE_ACC: begin
                if (cnt_q == '0) begin
                    state_d = S_CORE_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            // The core must release MIO_EN before a new access is accepted;
            // otherwise a level request would be served twice.
            S_CORE_HOLD: begin
                if (!bus.core_req) begin
                    state_d = S_IDLE;
                end
            end

            S_LDR_ACC: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.mdr_ld    = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ldr_ack   = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        addr_sel      = bus.mar_addr;
        wdata_sel     = bus.mdr_data;

        // Strobes are suppressed while reset is asserted so an access that
        // is being aborted never commits a write or returns ready.
        acc_done = (cnt_q == '0) && rst_n;

        case (state_q)
            S_CORE_ACC: begin
                if (acc_done) begin
                    bus.mem_ready = 1'b1;
                    if (we_q) begin
                        bus.ram_we = 1'b1;
                    end else begin
                        bus.mdr_ld = 1'b1;
                        bus.mem_en = 1'b1;
                    end
                end
            end

            S_LDR_ACC: begin
                addr_sel  = bus.ldr_addr;
                wdata_sel = bus.ldr_wdata;
                if (acc_done) begin
                    bus.ram_we  = 1'b1;
                    bus.ldr_ack = 1'b1;
                end
            end

            default: ;
        endcase
    end

    assign bus.ram_addr  = addr_sel;
    assign bus.ram_wdata = wdata_sel;

endmodule
